// File: rtl/regfile_wb_writer_if.sv
// Result-producer handshake bundle for the write-back writer: ALU path and load path.
interface regfile_wb_writer_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready
    );
endinterface

// File: rtl/regfile_wb_writer.sv
// Serialises ALU and load results through an in-order FIFO onto the register file's
// single write port, and reports per-register pending writes to decode.
module regfile_wb_writer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_writer_if.slave     wb,
    output logic                   RegWrite,
    output logic [4:0]             addD,
    output logic [XLEN-1:0]        WB_out,
    input  logic [4:0]             chk_a,
    input  logic [4:0]             chk_b,
    output logic                   pend_a,
    output logic                   pend_b,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;

    logic            push_ld;
    logic            push_alu;
    logic            push;
    logic            pop;
    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data;
    logic            hit_a;
    logic            hit_b;

    assign full         = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty        = (count == '0);
    assign wb.ld_ready  = !full;
    assign wb.alu_ready = !full && !wb.ld_valid;

    // x0 transfers complete the handshake but never occupy a slot.
    always_comb begin
        push_ld   = wb.ld_valid && wb.ld_ready;
        push_alu  = wb.alu_valid && wb.alu_ready;
        push_rd   = push_ld ? wb.ld_rd : wb.alu_rd;
        push_data = push_ld ? wb.ld_data : wb.alu_data;
        push      = (push_ld || push_alu) && (push_rd != '0);
        pop       = !empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            vld      <= '0;
            RegWrite <= 1'b0;
            addD     <= '0;
            WB_out   <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                addD      <= mem_rd[rptr];
                WB_out    <= mem_data[rptr];
                rptr      <= rptr + 1'b1;
                vld[rptr] <= 1'b0;
            end
            if (push) begin
                wptr      <= wptr + 1'b1;
                vld[wptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the per-slot valid bits gate every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wptr]   <= push_rd;
            mem_data[wptr] <= push_data;
        end
    end

    always_comb begin
        hit_a = RegWrite && (addD == chk_a);
        hit_b = RegWrite && (addD == chk_b);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld[i] && (mem_rd[i] == chk_a)) hit_a = 1'b1;
            if (vld[i] && (mem_rd[i] == chk_b)) hit_b = 1'b1;
        end
        pend_a = (chk_a != '0) && hit_a;
        pend_b = (chk_b != '0) && hit_b;
    end
endmodule

// File: tb/tb_regfile_wb_writer.sv
// Scoreboard bench for regfile_wb_writer: queue-level reference model, directed and random traffic.
module tb_regfile_wb_writer;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            RegWrite;
    logic [4:0]      addD;
    logic [XLEN-1:0] WB_out;
    logic [4:0]      chk_a = '0;
    logic [4:0]      chk_b = '0;
    logic            pend_a;
    logic            pend_b;
    logic [2:0]      count;
    logic            full;
    logic            empty;

    regfile_wb_writer_if #(.XLEN(XLEN)) bus ();

    regfile_wb_writer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (bus),
        .RegWrite (RegWrite),
        .addD     (addD),
        .WB_out   (WB_out),
        .chk_a    (chk_a),
        .chk_b    (chk_b),
        .pend_a   (pend_a),
        .pend_b   (pend_b),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    // sb: expected writes in acceptance order; mq: destinations still queued in the model FIFO;
    // mwr_*: write the model places on the register-file port after the last edge.
    wr_t        sb[$];
    logic [4:0] mq[$];
    bit         mwr_valid = 1'b0;
    logic [4:0] mwr_rd    = '0;
    logic [4:0]      last_rd   = '0;
    logic [XLEN-1:0] last_data = '0;
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_pend(input logic [4:0] c);
        if (c == '0) return 1'b0;
        if (mwr_valid && mwr_rd == c) return 1'b1;
        foreach (mq[i]) if (mq[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every write the DUT presents is popped from the scoreboard and compared.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst) begin
            check("RegWrite", RegWrite, mwr_valid);
            if (RegWrite) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addD=%0d WB_out=%0h expected no write", addD, WB_out);
                end else begin
                    e = sb.pop_front();
                    check("addD", addD, e.rd);
                    check("WB_out", WB_out, e.data);
                    last_rd   = e.rd;
                    last_data = e.data;
                end
            end else begin
                check("addD_hold", addD, last_rd);
                check("WB_out_hold", WB_out, last_data);
            end
            check("count", count, mq.size());
            check("empty", empty, mq.size() == 0);
            check("full", full, mq.size() == DEPTH);
            check("pend_a", pend_a, exp_pend(chk_a));
            check("pend_b", pend_b, exp_pend(chk_b));
        end
    end

    // One clock of stimulus: drive, check readies, then advance the model at the edge.
    task automatic step(input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
                        input bit av, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                        input logic [4:0] ca, input logic [4:0] cb, output bit alu_acc);
        bit  rdy;
        bit  acc_ld;
        wr_t w;
        @(negedge clk);
        #2;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ldat;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adat;
        chk_a         = ca;
        chk_b         = cb;
        #1;
        rdy = (mq.size() < DEPTH);
        check("ld_ready", bus.ld_ready, rdy);
        check("alu_ready", bus.alu_ready, rdy && !lv);
        acc_ld  = lv && rdy;
        alu_acc = av && rdy && !lv;
        @(posedge clk);
        if (rst) begin
            if (mq.size() > 0) begin
                mwr_valid = 1'b1;
                mwr_rd    = mq.pop_front();
            end else begin
                mwr_valid = 1'b0;
            end
            if (acc_ld && lrd != '0) begin
                w.rd = lrd; w.data = ldat;
                mq.push_back(lrd);
                sb.push_back(w);
            end else if (alu_acc && ard != '0) begin
                w.rd = ard; w.data = adat;
                mq.push_back(ard);
                sb.push_back(w);
            end
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, chk_a, chk_b, a);
    endtask

    initial begin
        bit              acc;
        bit              av;
        bit              lv;
        logic [4:0]      ard;
        logic [XLEN-1:0] adat;

        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        #1;
        check("rst_RegWrite", RegWrite, 0);
        check("rst_addD", addD, 0);
        check("rst_WB_out", WB_out, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ld_ready", bus.ld_ready, 1);
        bus.ld_valid = 1'b1;
        #1;
        check("rst_alu_ready_ld", bus.alu_ready, 0);
        bus.ld_valid = 1'b0;
        #1;
        check("rst_alu_ready", bus.alu_ready, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;

        // Single ALU write, then simultaneous offers.
        step(1'b0, '0, '0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0, acc);
        idle(3);
        step(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB, 5'd3, 5'd4, acc);
        step(1'b0, '0, '0, 1'b1, 5'd4, 32'hBB, 5'd3, 5'd4, acc);
        idle(3);

        // Write-after-write to x7, then an x0 discard.
        step(1'b1, 5'd7, 32'h11, 1'b0, '0, '0, 5'd7, 5'd1, acc);
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd1, acc);
        idle(3);
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0, acc);
        idle(2);

        // Reset while writes are in flight.
        step(1'b0, '0, '0, 1'b1, 5'd9, 32'h90, 5'd11, 5'd10, acc);
        step(1'b0, '0, '0, 1'b1, 5'd10, 32'hA0, 5'd11, 5'd10, acc);
        step(1'b0, '0, '0, 1'b1, 5'd11, 32'hB0, 5'd11, 5'd10, acc);
        @(negedge clk);
        #2;
        bus.alu_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_RegWrite", RegWrite, 0);
        check("midrst_addD", addD, 0);
        check("midrst_WB_out", WB_out, 0);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_pend_a", pend_a, 0);
        check("midrst_pend_b", pend_b, 0);
        sb.delete();
        mq.delete();
        mwr_valid = 1'b0;
        last_rd   = '0;
        last_data = '0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        idle(3);

        // Stream of eight back-to-back ALU results.
        for (int r = 1; r <= 8; r++)
            step(1'b0, '0, '0, 1'b1, 5'(r), 32'(r * 16), 5'(r), 5'(r - 1), acc);
        idle(3);

        // Randomised traffic; an ALU offer that was not taken is held stable.
        av = 1'b0; ard = '0; adat = '0; acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!av || acc) begin
                av   = ($urandom_range(0, 9) < 6);
                ard  = 5'($urandom_range(0, 7));
                adat = $urandom;
            end
            lv = ($urandom_range(0, 9) < 3);
            step(lv, 5'($urandom_range(0, 7)), $urandom, av, ard, adat,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
        end
        idle(4);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
